// File: rtl/imm_encode_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_encode_pipe
// Description : Packs a 32-bit value (absolute, or PC-relative target) into
//               the LA32R immediate field of an instruction template, using
//               the same format codes as the immediate extender. Flags
//               values that the selected format cannot represent.
//               Two-stage valid/ready pipeline, one result per cycle.
// Options     : IMM_ENC_STAT_EN - adds stat_clr/stat_req/stat_err ports and
//               saturating request / error counters.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encode_pipe #(
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_tmpl,
    input  logic [31:0]      in_val,
    input  logic [31:0]      in_pc,
    input  logic             in_rel,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_ENC_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] stat_req,
    output logic [CNT_W-1:0] stat_err
`endif
);

    // Format codes, identical to the extender's EXT_* encoding.
    localparam logic [2:0] c_EXT_2RI5U  = 3'd0;
    localparam logic [2:0] c_EXT_2RI12  = 3'd1;
    localparam logic [2:0] c_EXT_2RI12U = 3'd2;
    localparam logic [2:0] c_EXT_1RI20  = 3'd3;
    localparam logic [2:0] c_EXT_2RI16  = 3'd4;
    localparam logic [2:0] c_EXT_I26    = 3'd5;
    localparam logic [2:0] c_EXT_2RI14  = 3'd6;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_inst_q,  s1_inst_d;
    logic             s1_err_q,   s1_err_d;
    logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_inst_q,  s2_inst_d;
    logic             s2_err_q,   s2_err_d;
    logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

    logic w_s2_load;
    logic w_accept;

    // The output stage can take new data when it is empty or being consumed;
    // stage 1 can take new data when it is empty or draining into stage 2.
    assign w_s2_load = ~s2_valid_q | out_ready;
    assign in_ready  = ~s1_valid_q | w_s2_load;
    assign w_accept  = in_valid & in_ready;

    // ------------------------------------------------------------------
    // Encoder
    // ------------------------------------------------------------------
    logic [31:0] w_off;
    logic [31:0] w_mask;
    logic [31:0] w_field;
    logic        w_err;

    // Relative requests encode the distance from the instruction's own PC.
    assign w_off = in_rel ? (in_val - in_pc) : in_val;

    // Select the field placement and the representability test per format.
    always_comb begin
        w_mask  = 32'h0;
        w_field = 32'h0;
        w_err   = 1'b0;
        case (in_op)
            c_EXT_2RI5U: begin
                w_mask[14:10]  = 5'h1F;
                w_field[14:10] = w_off[4:0];
                w_err          = |w_off[31:5];
            end
            c_EXT_2RI12: begin
                w_mask[21:10]  = 12'hFFF;
                w_field[21:10] = w_off[11:0];
                w_err          = (w_off[31:11] != {21{w_off[31]}});
            end
            c_EXT_2RI12U: begin
                w_mask[21:10]  = 12'hFFF;
                w_field[21:10] = w_off[11:0];
                w_err          = |w_off[31:12];
            end
            c_EXT_1RI20: begin
                w_mask[24:5]   = 20'hFFFFF;
                w_field[24:5]  = w_off[31:12];
                w_err          = |w_off[11:0];
            end
            c_EXT_2RI16: begin
                w_mask[25:10]  = 16'hFFFF;
                w_field[25:10] = w_off[17:2];
                w_err          = (|w_off[1:0]) |
                                 (w_off[31:17] != {15{w_off[31]}});
            end
            c_EXT_I26: begin
                // Low 16 offset bits sit above the high 10, as in b/bl.
                w_mask[25:0]   = 26'h3FFFFFF;
                w_field[25:10] = w_off[17:2];
                w_field[9:0]   = w_off[27:18];
                w_err          = (|w_off[1:0]) |
                                 (w_off[31:27] != {5{w_off[31]}});
            end
            c_EXT_2RI14: begin
                w_mask[23:10]  = 14'h3FFF;
                w_field[23:10] = w_off[15:2];
                w_err          = (|w_off[1:0]) |
                                 (w_off[31:15] != {17{w_off[31]}});
            end
            default: begin
                // Any unlisted code stores the raw low 26 bits.
                w_mask[25:0]   = 26'h3FFFFFF;
                w_field[25:0]  = w_off[25:0];
                w_err          = |w_off[31:26];
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline next-state
    // ------------------------------------------------------------------

    // Stage 1 captures the packed instruction on accept, otherwise holds or empties.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_inst_d  = s1_inst_q;
        s1_err_d   = s1_err_q;
        s1_tag_d   = s1_tag_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (w_accept) begin
            s1_inst_d = (in_tmpl & ~w_mask) | (w_field & w_mask);
            s1_err_d  = w_err;
            s1_tag_d  = in_tag;
        end
    end

    // Stage 2 (output register) takes stage 1 whenever it is free to move.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        s2_tag_d   = s2_tag_q;
        if (w_s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = s1_inst_q;
                s2_err_d  = s1_err_q;
                s2_tag_d  = s1_tag_q;
            end
        end
    end

    // Pipeline registers; reset drops anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= 32'h0;
            s1_err_q   <= 1'b0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_inst_q  <= 32'h0;
            s2_err_q   <= 1'b0;
            s2_tag_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            s1_err_q   <= s1_err_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_inst_q  <= s2_inst_d;
            s2_err_q   <= s2_err_d;
            s2_tag_q   <= s2_tag_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_inst  = s2_inst_q;
    assign out_err   = s2_err_q;
    assign out_tag   = s2_tag_q;

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef IMM_ENC_STAT_EN
    logic [CNT_W-1:0] stat_req_q, stat_req_d;
    logic [CNT_W-1:0] stat_err_q, stat_err_d;
    logic             w_err_done;

    assign w_err_done = s2_valid_q & out_ready & s2_err_q;

    // Saturating counters; a clear overrides a same-cycle increment.
    always_comb begin
        stat_req_d = stat_req_q;
        stat_err_d = stat_err_q;
        if (stat_clr) begin
            stat_req_d = '0;
            stat_err_d = '0;
        end else begin
            if (w_accept && (stat_req_q != {CNT_W{1'b1}})) begin
                stat_req_d = stat_req_q + 1'b1;
            end
            if (w_err_done && (stat_err_q != {CNT_W{1'b1}})) begin
                stat_err_d = stat_err_q + 1'b1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_req_q <= '0;
            stat_err_q <= '0;
        end else begin
            stat_req_q <= stat_req_d;
            stat_err_q <= stat_err_d;
        end
    end

    assign stat_req = stat_req_q;
    assign stat_err = stat_err_q;
`else
    // Counter width only matters when statistics are built in.
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule
`default_nettype wire
